// File: rtl/gps_encoder.sv
// NMEA $GPRMC sentence encoder: captures a position, converts it to BCD, streams ASCII bytes.
// Define GPS_ENCODER_CHECKSUM_EN to append the *CC checksum field (44-byte sentence, else 41).
module gps_encoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        gps_valid,
    input  logic        north,
    input  logic        east,
    input  logic [7:0]  latd,
    input  logic [19:0] latm,
    input  logic [7:0]  lond,
    input  logic [19:0] lonm,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        range_err,
    output logic [1:0]  dbg_state
);

`ifdef GPS_ENCODER_CHECKSUM_EN
    localparam logic [5:0] LAST_IDX = 6'd43;
`else
    localparam logic [5:0] LAST_IDX = 6'd40;
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CONVERT = 2'd1, S_SEND = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [5:0]  idx_q, idx_d;
    // Each field register is {bcd[27:0], bin[19:0]}; the BCD digits end up in bits [47:20].
    logic [47:0] latd_sh_q, latd_sh_d;
    logic [47:0] latm_sh_q, latm_sh_d;
    logic [47:0] lond_sh_q, lond_sh_d;
    logic [47:0] lonm_sh_q, lonm_sh_d;
    logic        gps_valid_q, gps_valid_d;
    logic        north_q, north_d;
    logic        east_q, east_d;
    logic        range_err_q, range_err_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [5:0]  nxt_idx;
    logic [7:0]  next_byte;
`ifdef GPS_ENCODER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    function automatic logic [47:0] dd_step(input logic [47:0] v);
        logic [47:0] t;
        t = v;
        for (int i = 0; i < 7; i++) begin
            if (t[20+4*i +: 4] >= 4'd5) t[20+4*i +: 4] = t[20+4*i +: 4] + 4'd3;
        end
        return {t[46:0], 1'b0};
    endfunction

    function automatic logic [7:0] asc(input logic [3:0] d);
        return {4'h3, d};
    endfunction

`ifdef GPS_ENCODER_CHECKSUM_EN
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction
`endif

    assign nxt_idx = idx_q + 6'd1;

    always_comb begin
        next_byte = 8'h00;
        case (nxt_idx)
            6'd1:  next_byte = "G";
            6'd2:  next_byte = "P";
            6'd3:  next_byte = "R";
            6'd4:  next_byte = "M";
            6'd5:  next_byte = "C";
            6'd8:  next_byte = (gps_valid_q && !range_err_q) ? "A" : "V";
            6'd10: next_byte = asc(latd_sh_q[27:24]);
            6'd11: next_byte = asc(latd_sh_q[23:20]);
            6'd12: next_byte = asc(latm_sh_q[43:40]);
            6'd13: next_byte = asc(latm_sh_q[39:36]);
            6'd14: next_byte = ".";
            6'd15: next_byte = asc(latm_sh_q[35:32]);
            6'd16: next_byte = asc(latm_sh_q[31:28]);
            6'd17: next_byte = asc(latm_sh_q[27:24]);
            6'd18: next_byte = asc(latm_sh_q[23:20]);
            6'd20: next_byte = north_q ? "N" : "S";
            6'd22: next_byte = asc(lond_sh_q[31:28]);
            6'd23: next_byte = asc(lond_sh_q[27:24]);
            6'd24: next_byte = asc(lond_sh_q[23:20]);
            6'd25: next_byte = asc(lonm_sh_q[43:40]);
            6'd26: next_byte = asc(lonm_sh_q[39:36]);
            6'd27: next_byte = ".";
            6'd28: next_byte = asc(lonm_sh_q[35:32]);
            6'd29: next_byte = asc(lonm_sh_q[31:28]);
            6'd30: next_byte = asc(lonm_sh_q[27:24]);
            6'd31: next_byte = asc(lonm_sh_q[23:20]);
            6'd33: next_byte = east_q ? "E" : "W";
            6'd6, 6'd7, 6'd9, 6'd19, 6'd21, 6'd32,
            6'd34, 6'd35, 6'd36, 6'd37, 6'd38: next_byte = ",";
`ifdef GPS_ENCODER_CHECKSUM_EN
            6'd39: next_byte = "*";
            6'd40: next_byte = hex_ascii(csum_q[7:4]);
            6'd41: next_byte = hex_ascii(csum_q[3:0]);
            6'd42: next_byte = 8'h0d;
            6'd43: next_byte = 8'h0a;
`else
            6'd39: next_byte = 8'h0d;
            6'd40: next_byte = 8'h0a;
`endif
            default: next_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        latd_sh_d   = latd_sh_q;
        latm_sh_d   = latm_sh_q;
        lond_sh_d   = lond_sh_q;
        lonm_sh_d   = lonm_sh_q;
        gps_valid_d = gps_valid_q;
        north_d     = north_q;
        east_d      = east_q;
        range_err_d = range_err_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef GPS_ENCODER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_CONVERT;
                    cnt_d       = 5'd0;
                    busy_d      = 1'b1;
                    latd_sh_d   = {40'd0, latd};
                    latm_sh_d   = {28'd0, latm};
                    lond_sh_d   = {40'd0, lond};
                    lonm_sh_d   = {28'd0, lonm};
                    gps_valid_d = gps_valid;
                    north_d     = north;
                    east_d      = east;
                    range_err_d = (latd > 8'd90) || (lond > 8'd180) ||
                                  (latm > 20'd599999) || (lonm > 20'd599999);
                end
            end
            S_CONVERT: begin
                latd_sh_d = dd_step(latd_sh_q);
                latm_sh_d = dd_step(latm_sh_q);
                lond_sh_d = dd_step(lond_sh_q);
                lonm_sh_d = dd_step(lonm_sh_q);
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q == 5'd19) begin
                    state_d    = S_SEND;
                    idx_d      = 6'd0;
                    tx_data_d  = 8'h24;
                    tx_valid_d = 1'b1;
`ifdef GPS_ENCODER_CHECKSUM_EN
                    csum_d     = 8'h00;
`endif
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = S_IDLE;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        idx_d     = nxt_idx;
                        tx_data_d = next_byte;
`ifdef GPS_ENCODER_CHECKSUM_EN
                        // Checksum covers bytes 1..38, i.e. everything between '$' and '*'.
                        if (idx_q >= 6'd1 && idx_q <= 6'd38) csum_d = csum_q ^ tx_data_q;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            idx_q       <= 6'd0;
            latd_sh_q   <= 48'd0;
            latm_sh_q   <= 48'd0;
            lond_sh_q   <= 48'd0;
            lonm_sh_q   <= 48'd0;
            gps_valid_q <= 1'b0;
            north_q     <= 1'b0;
            east_q      <= 1'b0;
            range_err_q <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef GPS_ENCODER_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            latd_sh_q   <= latd_sh_d;
            latm_sh_q   <= latm_sh_d;
            lond_sh_q   <= lond_sh_d;
            lonm_sh_q   <= lonm_sh_d;
            gps_valid_q <= gps_valid_d;
            north_q     <= north_d;
            east_q      <= east_d;
            range_err_q <= range_err_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef GPS_ENCODER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign range_err = range_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gps_encoder.sv
// Bench for gps_encoder: scoreboarded byte stream against a decimal-arithmetic sentence model.
// Handshake: a byte moves on a rising edge with tx_valid=1 and tx_ready=1; sampled on the falling edge.
module tb_gps_encoder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        gps_valid = 1'b0;
    logic        north = 1'b0;
    logic        east = 1'b0;
    logic [7:0]  latd = 8'd0;
    logic [19:0] latm = 20'd0;
    logic [7:0]  lond = 8'd0;
    logic [19:0] lonm = 20'd0;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;
    logic        range_err;
    logic [1:0]  dbg_state;

`ifdef GPS_ENCODER_CHECKSUM_EN
    localparam int LEN = 44;
`else
    localparam int LEN = 41;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          tx_cnt = 0;
    int          done_cnt = 0;
    int          stall_checks = 0;
    bit          bp_en = 1'b0;
    bit          stall_pend = 1'b0;
    logic [7:0]  stall_data = 8'h00;

    gps_encoder dut (
        .clk(clk), .reset_n(reset_n), .start(start), .gps_valid(gps_valid),
        .north(north), .east(east), .latd(latd), .latm(latm), .lond(lond), .lonm(lonm),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .done(done), .range_err(range_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic logic [7:0] dig(input int v, input int p);
        return 8'h30 + 8'((v / p) % 10);
    endfunction

    function automatic logic [7:0] hexc(input int n);
        return (n < 10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10);
    endfunction

    task automatic push_sentence(input int la_d, input int la_m, input bit n, input int lo_d,
                                 input int lo_m, input bit e, input bit v);
        logic [7:0] s[$];
        logic [7:0] cs;
        bit rerr;
        rerr = (la_d > 90) || (lo_d > 180) || (la_m > 599999) || (lo_m > 599999);
        s = {"$", "G", "P", "R", "M", "C", ",", ","};
        s.push_back((v && !rerr) ? "A" : "V");
        s.push_back(",");
        s.push_back(dig(la_d, 10)); s.push_back(dig(la_d, 1));
        s.push_back(dig(la_m, 100000)); s.push_back(dig(la_m, 10000)); s.push_back(".");
        s.push_back(dig(la_m, 1000)); s.push_back(dig(la_m, 100));
        s.push_back(dig(la_m, 10)); s.push_back(dig(la_m, 1));
        s.push_back(","); s.push_back(n ? "N" : "S"); s.push_back(",");
        s.push_back(dig(lo_d, 100)); s.push_back(dig(lo_d, 10)); s.push_back(dig(lo_d, 1));
        s.push_back(dig(lo_m, 100000)); s.push_back(dig(lo_m, 10000)); s.push_back(".");
        s.push_back(dig(lo_m, 1000)); s.push_back(dig(lo_m, 100));
        s.push_back(dig(lo_m, 10)); s.push_back(dig(lo_m, 1));
        s.push_back(","); s.push_back(e ? "E" : "W");
        for (int i = 0; i < 5; i++) s.push_back(",");
`ifdef GPS_ENCODER_CHECKSUM_EN
        cs = 8'h00;
        for (int i = 1; i < s.size(); i++) cs = cs ^ s[i];
        s.push_back("*");
        s.push_back(hexc(int'(cs[7:4])));
        s.push_back(hexc(int'(cs[3:0])));
`else
        cs = 8'h00;
`endif
        s.push_back(8'h0d);
        s.push_back(8'h0a);
        foreach (s[i]) exp_q.push_back(s[i]);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [7:0] e;
        if (reset_n) begin
            if (stall_pend) begin
                checks++;
                stall_checks++;
                if (!tx_valid || tx_data !== stall_data) begin
                    errors++;
                    $display("FAIL stall_hold got valid=%0d data=%h expected valid=1 data=%h",
                             tx_valid, tx_data, stall_data);
                end
            end
            stall_pend = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte got %h expected none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL byte got %h expected %h", tx_data, e);
                    end
                end
                tx_cnt++;
            end
            if (done) done_cnt++;
        end else begin
            stall_pend = 1'b0;
        end
    end

    // ---------------- drivers ----------------
    task automatic start_sentence(input int la_d, input int la_m, input bit n, input int lo_d,
                                  input int lo_m, input bit e, input bit v);
        latd = 8'(la_d); latm = 20'(la_m); north = n;
        lond = 8'(lo_d); lonm = 20'(lo_m); east = e; gps_valid = v;
        start = 1'b1;
        push_sentence(la_d, la_m, n, lo_d, lo_m, e, v);
        @(posedge clk); #1;
        start = 1'b0;
        latd = 8'($urandom); latm = 20'($urandom); lond = 8'($urandom);
        lonm = 20'($urandom); north = 1'($urandom); east = 1'($urandom);
        gps_valid = 1'($urandom);
    endtask

    task automatic pulse_start_only();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h expected 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b expected 0", done); end
        checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL rst_range_err got %b expected 0", range_err); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d expected 0", dbg_state); end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int first, run, done_at;
        first = -1; run = 0; done_at = -1;
        start_sentence(47, 367512, 1'b1, 122, 195049, 1'b0, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b expected 1", busy); end
        checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL basic_range_err got %b expected 0", range_err); end
        for (int k = 1; k <= 21 + LEN + 5; k++) begin
            @(negedge clk);
            if (tx_valid) begin
                if (first < 0) first = k;
                run++;
            end
            if (done && done_at < 0) done_at = k;
            @(posedge clk);
        end
        #1;
        checks++; if (first != 21) begin errors++; $display("FAIL basic_latency got %0d expected 21", first); end
        checks++; if (run != LEN) begin errors++; $display("FAIL basic_valid_cycles got %0d expected %0d", run, LEN); end
        checks++; if (done_at != 21 + LEN) begin errors++; $display("FAIL basic_done_cycle got %0d expected %0d", done_at, 21 + LEN); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_leftover got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int s0;
        s0 = stall_checks;
        bp_en = 1'b1;
        start_sentence(47, 367512, 1'b1, 122, 195049, 1'b0, 1'b1);
        wait_done(800, ok);
        bp_en = 1'b0;
        @(posedge clk); #1;
        checks++; if (!ok) begin errors++; $display("FAIL bp_done got timeout expected done"); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_leftover got %0d expected 0", exp_q.size()); end
        checks++; if (stall_checks == s0) begin errors++; $display("FAIL bp_stalls got 0 expected nonzero"); end
    endtask

    task automatic test_range();
        bit ok;
        start_sentence(95, 123456, 1'b0, 7, 5, 1'b1, 1'b1);
        checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_set got %b expected 1", range_err); end
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL range_done got timeout expected done"); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL range_leftover got %0d expected 0", exp_q.size()); end
        checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_latched got %b expected 1", range_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        start_sentence(90, 599999, 1'b1, 180, 599999, 1'b1, 1'b1);
        checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL b2b_range_clear got %b expected 0", range_err); end
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_done1 got timeout expected done"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_at_done got %b expected 0", busy); end
        start_sentence(255, 600000, 1'b0, 0, 0, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b expected 1", busy); end
        checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL b2b_range_set got %b expected 1", range_err); end
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_done2 got timeout expected done"); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d expected 0", exp_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_start();
        bit ok;
        int d0, c0;
        d0 = done_cnt; c0 = tx_cnt;
        start_sentence(12, 34567, 1'b1, 89, 400000, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        pulse_start_only();
        for (int i = 0; i < 40; i++) begin
            if (tx_valid) break;
            @(posedge clk); #1;
        end
        repeat (10) @(posedge clk);
        #1;
        pulse_start_only();
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ign_done got timeout expected done"); end
        repeat (30) @(posedge clk);
        #1;
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ign_done_count got %0d expected 1", done_cnt - d0); end
        checks++; if (tx_cnt - c0 != LEN) begin errors++; $display("FAIL ign_byte_count got %0d expected %0d", tx_cnt - c0, LEN); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy got %b expected 0", busy); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ign_leftover got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_abort();
        bit ok;
        bit hit;
        int c0;
        c0 = tx_cnt; hit = 1'b0;
        start_sentence(47, 367512, 1'b1, 122, 195049, 1'b0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (tx_cnt - c0 >= 15) begin
                hit = 1'b1;
                break;
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL abort_reach got %0d bytes expected 15", tx_cnt - c0); end
        reset_n = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL abort_tx_valid got %b expected 0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", busy); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL abort_tx_data got %h expected 00", tx_data); end
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_resume got valid=%b busy=%b expected 0 0", tx_valid, busy); end
        start_sentence(47, 367512, 1'b1, 122, 195049, 1'b0, 1'b1);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_restart got timeout expected done"); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_leftover got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_range();
        test_back_to_back();
        test_ignored_start();
        test_reset_abort();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gps_encoder.md
GPS_ENCODER -- requirements
Module: gps_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: `clk` input 1, rising-edge clock; `reset_n` input 1, asynchronous active-low reset.
REQ-002 The block SHALL provide `start`, input, 1 bit: one-cycle request to emit a sentence; ignored while `busy`=1.
REQ-003 The block SHALL provide `gps_valid`, `north` and `east`, inputs, 1 bit each: status A/V, N/S and E/W flags.
REQ-004 The block SHALL provide `latd` and `lond`, inputs, 8 bits each: degrees in binary.
REQ-005 The block SHALL provide `latm` and `lonm`, inputs, 20 bits each: minutes x10000 in binary, legal range 0..599999.
REQ-006 The block SHALL provide `tx_data`, output, 8 bits: ASCII byte to the UART transmitter.
REQ-007 The block SHALL provide `tx_valid` (output, 1 bit) and `tx_ready` (input, 1 bit): a byte transfers on a rising edge where both are 1.
REQ-008 The block SHALL provide `busy`, output, 1 bit: high from the accepted `start` until the cycle after the last byte transfers.
REQ-009 The block SHALL provide `done`, output, 1 bit: one-cycle pulse after the final byte transfers.
REQ-010 The block SHALL provide `range_err`, output, 1 bit: latched out-of-range flag for the current or last sentence.

Function
REQ-011 On a `start` seen while idle, the block SHALL capture all field inputs into holding registers; later input changes SHALL NOT affect the sentence.
REQ-012 The block SHALL implement states IDLE -> CONVERT -> SEND -> IDLE.
REQ-013 CONVERT SHALL last exactly 20 cycles and SHALL run sequential shift-add-3 binary-to-BCD conversion on all four fields in parallel.
REQ-014 SEND SHALL be entered on the cycle after CONVERT ends.
REQ-015 The emitted sentence SHALL be `$GPRMC,,S,DDMM.MMMM,H,DDDMM.MMMM,E,,,,,*CC<CR><LF>`.
REQ-016 In that sentence, S = `A` if `gps_valid`=1 and `range_err`=0, else `V`.
REQ-017 In that sentence, H = `N`/`S` per `north` and E = `E`/`W` per `east`.
REQ-018 Latitude degrees SHALL be 2 digits, longitude degrees 3 digits, each minutes field `MM.MMMM` 6 digits, all zero-padded.
REQ-019 Digits SHALL be the low decimal digits of the value (value mod 10^n).
REQ-020 `range_err` SHALL be set at capture when `latd`>90, `lond`>180, `latm`>599999 or `lonm`>599999, and SHALL be cleared at the next capture.
REQ-021 CC SHALL be the XOR of every byte strictly between `$` and `*`, emitted as two uppercase hex ASCII digits, high nibble first.
REQ-022 The checksum SHALL be accumulated in the same cycle each byte transfers.
REQ-023 `tx_valid` SHALL be 1 throughout SEND.
REQ-024 `tx_data` SHALL hold stable while `tx_valid`=1 and `tx_ready`=0.
REQ-025 Each accepted byte SHALL advance the byte index by one; no byte SHALL be skipped or repeated.
REQ-026 With `tx_ready` held at 1, one byte SHALL transfer per cycle (full throughput).
REQ-027 After the LF transfers, the block SHALL drop `tx_valid` and pulse `done` on the next cycle, with `busy`=0 in that same cycle.
REQ-028 A `start` arriving in the same cycle as `done` SHALL be accepted.
REQ-029 Back-to-back sentences SHALL therefore have one idle cycle between them.

Reset
REQ-030 When `reset_n`=0, the block SHALL asynchronously go to IDLE and zero the byte index, checksum, holding registers and BCD registers.
REQ-031 When `reset_n`=0, outputs SHALL be `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `done`=0 and `range_err`=0.
REQ-032 Reset asserted mid-sentence SHALL abort the sentence; nothing SHALL resume after reset release.
REQ-033 The first `start` after reset release SHALL emit a complete sentence from `$`.

Configuration
REQ-034 With macro `GPS_ENCODER_CHECKSUM_EN` defined, the block SHALL emit `*CC` before CR LF, for a sentence length of 44 bytes.
REQ-035 Without `GPS_ENCODER_CHECKSUM_EN`, the block SHALL emit CR LF directly after the last comma, for a sentence length of 41 bytes, and SHALL NOT include the checksum logic.

Verification
REQ-036 Basic sentence scenario: stimulus `latd`=47, `latm`=367512, N, `lond`=122, `lonm`=195049, W, `gps_valid`=1, `tx_ready`=1. Required: bytes `$GPRMC,,A,4736.7512,N,12219.5049,W,,,,,*CC\r\n`, CC matching the bench XOR model, `tx_valid` high 44 consecutive cycles starting 21 cycles after `start`.
REQ-037 Backpressure scenario: stimulus as REQ-036 with `tx_ready` randomly low about 50% of cycles. Required: identical byte sequence, with `tx_data` unchanged across every stalled cycle.
REQ-038 Range and padding scenario: stimulus `latd`=95, `lond`=7, `lonm`=5. Required: `range_err`=1, status `V`, fields `95`, `007`, `00.0005`.
REQ-039 Ignored start scenario: stimulus `start` pulsed during CONVERT and again during SEND. Required: ignored, exactly one sentence emitted, and one `done` pulse.
REQ-040 Reset abort scenario: stimulus `reset_n` low during byte 15. Required: `tx_valid`=0 immediately; the next `start` yields a full sentence beginning with `$`.
REQ-041 Configuration scenario: build without `GPS_ENCODER_CHECKSUM_EN`, stimulus as REQ-036. Required: 41 bytes, with `,` followed by CR LF at the end and no `*`.
